// File: rtl/cpu3_pkg.sv
// cpu3_pkg: shared widths, loader state encoding and CPU opcodes for the 3-bit CPU.
//  WORD_W  instruction width (2-bit opcode + 1-bit data)
//  DEPTH   instruction words per program
//  ADDR_W  instruction-memory address width
package cpu3_pkg;
    localparam int WORD_W = 3;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_ADD,
        OP_SUB,
        OP_STORE
    } opcode_t;
endpackage

// File: rtl/ser_word_rx.sv
// ser_word_rx: MSB-first bit-serial to parallel word assembler.
//  clk, reset   clock and synchronous active-high reset
//  clear        restart word assembly (start of a new load)
//  accept       a serial bit is transferred this cycle
//  ser_bit      serial data bit
//  word_valid   combinational pulse when the accepted bit completes a word
//  word         completed word, valid alongside word_valid
module ser_word_rx
    import cpu3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              ser_bit,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    localparam int CNT_W = $clog2(WORD_W);

    // Only the WORD_W-1 older bits need storing; the newest bit is taken live.
    logic [WORD_W-2:0] shift;
    logic [CNT_W-1:0]  bit_cnt;

    always_comb begin
        word       = {shift, ser_bit};
        word_valid = accept && bit_cnt == CNT_W'(WORD_W - 1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shift   <= word[WORD_W-2:0];
            bit_cnt <= word_valid ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: serial boot loader writing DEPTH words into instruction memory, then verifying a checksum.
//  clk, reset    clock and synchronous active-high reset
//  load_start    starts a load from IDLE/DONE/ERROR
//  ser_valid     serial bit valid; ser_bit serial data, MSB first
//  ser_ready     bits accepted while high (RECV/CHECK)
//  imem_we/addr/wdata  instruction-memory write port, one pulse per word
//  cpu_reset     holds the CPU in reset unless the last load succeeded
//  load_busy/load_done/load_error  loader status
module program_loader
    import cpu3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              ser_valid,
    input  logic              ser_bit,
    output logic              ser_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);
    ld_state_t         state, nxt;
    logic [ADDR_W-1:0] word_cnt;
    logic [WORD_W-1:0] sum, word;
    logic              accept, honour, word_valid, last;

    ser_word_rx u_rx (
        .clk        (clk),
        .reset      (reset),
        .clear      (honour),
        .accept     (accept),
        .ser_bit    (ser_bit),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        accept = ser_valid && ser_ready;
        honour = load_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
        last   = word_cnt == ADDR_W'(DEPTH - 1);
        nxt    = honour                                      ? ST_RECV  :
                 (state == ST_RECV && word_valid && last)    ? ST_CHECK :
                 (state == ST_CHECK && word_valid)           ? (word == sum ? ST_DONE : ST_ERROR) :
                 state;
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ser_ready  <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            sum        <= '0;
        end else begin
            state      <= nxt;
            ser_ready  <= nxt == ST_RECV || nxt == ST_CHECK;
            load_busy  <= nxt == ST_RECV || nxt == ST_CHECK;
            load_done  <= nxt == ST_DONE;
            load_error <= nxt == ST_ERROR;
            cpu_reset  <= nxt != ST_DONE;
            imem_we    <= state == ST_RECV && word_valid;
            if (honour) begin
                word_cnt <= '0;
                sum      <= '0;
            end else if (state == ST_RECV && word_valid) begin
                imem_addr  <= word_cnt;
                imem_wdata <= word;
                sum        <= sum + word;
                word_cnt   <= last ? word_cnt : word_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader; writes are queued as issued and checked by a monitor.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_bit = 1'b0;
    logic       ser_ready, imem_we, cpu_reset, load_busy, load_done, load_error;
    logic [2:0] imem_addr;
    logic [2:0] imem_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .ser_ready  (ser_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL write: unexpected addr=%0d data=%0d", imem_addr, imem_wdata);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             imem_addr, imem_wdata, e[5:3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        ser_valid = 1'b1;
        ser_bit   = b;
        while (!ser_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ser_ready: got 0 want 1 within 50 cycles");
        end
        tick();
        ser_valid = 1'b0;
    endtask

    // Sends words w[0..nw-1]; words below index 8 are expected as writes.
    task automatic send_prog(input logic [2:0] w[9], input int nw, input bit gaps, input int pulse_idx);
        for (int i = 0; i < nw; i++) begin
            if (i < 8) exp_q.push_back({3'(i), w[i]});
            for (int j = 2; j >= 0; j--) begin
                if (i == pulse_idx && j == 1) load_start = 1'b1;
                send_bit(w[i][j]);
                load_start = 1'b0;
                if (gaps) repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    logic [2:0] prog_ok[9]  = '{3'd0, 3'd3, 3'd3, 3'd2, 3'd6, 3'd1, 3'd2, 3'd7, 3'd0};
    logic [2:0] prog_bad[9] = '{3'd0, 3'd3, 3'd3, 3'd2, 3'd6, 3'd1, 3'd2, 3'd7, 3'd3};
    logic [2:0] prog_five[9] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check("rst cpu_reset", 8'(cpu_reset), 8'd1);
        check("rst ser_ready", 8'(ser_ready), 8'd0);
        check("rst imem_we", 8'(imem_we), 8'd0);
        check("rst load_done", 8'(load_done), 8'd0);
        check("rst load_error", 8'(load_error), 8'd0);
        check("rst imem_addr", 8'(imem_addr), 8'd0);

        // Bit offered during the load_start cycle must be dropped.
        ser_valid = 1'b1;
        ser_bit   = 1'b1;
        pulse_start();
        ser_valid = 1'b0;
        check("start busy", 8'(load_busy), 8'd1);
        send_prog(prog_ok, 9, 1'b0, -1);
        check("t2 done", 8'(load_done), 8'd1);
        check("t2 cpu_reset", 8'(cpu_reset), 8'd0);
        check("t2 busy", 8'(load_busy), 8'd0);

        pulse_start();
        send_prog(prog_bad, 9, 1'b0, -1);
        check("t3 error", 8'(load_error), 8'd1);
        check("t3 done", 8'(load_done), 8'd0);
        check("t3 cpu_reset", 8'(cpu_reset), 8'd1);

        pulse_start();
        send_prog(prog_ok, 9, 1'b1, 4);
        check("t4 done", 8'(load_done), 8'd1);
        check("t4 cpu_reset", 8'(cpu_reset), 8'd0);

        pulse_start();
        send_prog(prog_five, 4, 1'b0, -1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 rst cpu_reset", 8'(cpu_reset), 8'd1);
        check("t5 rst busy", 8'(load_busy), 8'd0);
        check("t5 rst pending", 8'(exp_q.size()), 8'd0);
        pulse_start();
        send_prog(prog_five, 9, 1'b0, -1);
        check("t5 done", 8'(load_done), 8'd1);

        pulse_start();
        check("t6 cpu_reset", 8'(cpu_reset), 8'd1);
        check("t6 busy", 8'(load_busy), 8'd1);
        check("t6 done", 8'(load_done), 8'd0);

        repeat (3) tick();
        check("writes pending", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
